// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues pipelined word fetches and buffers results in a prefetch queue.
// Define IF_ALIGN_CHECK_EN to turn misaligned redirect targets into a fault entry (id_exc) instead of aligning them.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst
`ifdef IF_ALIGN_CHECK_EN
   ,
   output logic        id_exc
`endif
);

   localparam int          PW      = $clog2(DEPTH);
   localparam int          CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [PW-1:0]    fill_q, fill_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    unfilled_q, unfilled_d;
   logic [CW-1:0]    drop_q, drop_d;
   logic [31:0]      pc_mem_q   [DEPTH];
   logic [31:0]      inst_mem_q [DEPTH];
   logic [DEPTH-1:0] filled_q;

   logic             fire;
   logic             resp_drop;
   logic             resp_fill;
   logic             resp_any;
   logic             pop;
   logic             misalign;
   logic [31:0]      target_pc;

`ifdef IF_ALIGN_CHECK_EN
   logic             halt_q, halt_d;
   logic [DEPTH-1:0] exc_q;
`endif

   // Outstanding requests plus queued entries plus stale responses never exceed DEPTH.
   always_comb begin
      imem_req_valid = !rst && (({1'b0, count_q} + {1'b0, drop_q}) < DEPTH_C);
`ifdef IF_ALIGN_CHECK_EN
      if (halt_q) begin
         imem_req_valid = 1'b0;
      end
`endif
      imem_req_addr = fetch_pc_q;
   end

   always_comb begin
      fire      = imem_req_valid && imem_req_ready;
      resp_drop = imem_resp_valid && (drop_q != '0);
      resp_fill = imem_resp_valid && (drop_q == '0) && (unfilled_q != '0);
      resp_any  = resp_drop || resp_fill;
      pop       = id_valid && id_ready;
`ifdef IF_ALIGN_CHECK_EN
      target_pc = redirect_pc;
      misalign  = (redirect_pc[1:0] != 2'b00);
`else
      target_pc = redirect_pc & 32'hFFFF_FFFC;
      misalign  = 1'b0;
`endif
   end

   // Responses in flight at a redirect, including this cycle's fire, belong to the old stream.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      head_d     = head_q;
      tail_d     = tail_q;
      fill_d     = fill_q;
      count_d    = count_q;
      unfilled_d = unfilled_q;
      drop_d     = drop_q;
`ifdef IF_ALIGN_CHECK_EN
      halt_d     = halt_q;
`endif
      if (redirect_valid) begin
         fetch_pc_d = target_pc;
         head_d     = '0;
         tail_d     = '0;
         fill_d     = '0;
         count_d    = '0;
         unfilled_d = '0;
         drop_d     = drop_q + unfilled_q + CW'(fire) - CW'(resp_any);
`ifdef IF_ALIGN_CHECK_EN
         halt_d     = misalign;
         if (misalign) begin
            tail_d  = PW'(1);
            fill_d  = PW'(1);
            count_d = CW'(1);
         end
`endif
      end else begin
         if (fire) begin
            tail_d     = tail_q + PW'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (resp_drop) begin
            drop_d = drop_q - CW'(1);
         end
         if (resp_fill) begin
            fill_d = fill_q + PW'(1);
         end
         if (pop) begin
            head_d = head_q + PW'(1);
         end
         count_d    = count_q + CW'(fire) - CW'(pop);
         unfilled_d = unfilled_q + CW'(fire) - CW'(resp_fill);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         head_q     <= '0;
         tail_q     <= '0;
         fill_q     <= '0;
         count_q    <= '0;
         unfilled_q <= '0;
         drop_q     <= '0;
`ifdef IF_ALIGN_CHECK_EN
         halt_q     <= 1'b0;
`endif
      end else begin
         fetch_pc_q <= fetch_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         fill_q     <= fill_d;
         count_q    <= count_d;
         unfilled_q <= unfilled_d;
         drop_q     <= drop_d;
`ifdef IF_ALIGN_CHECK_EN
         halt_q     <= halt_d;
`endif
      end
   end

   // Payload storage needs no reset; outputs are gated by the filled flags.
   always_ff @(posedge clk) begin
      if (fire) begin
         pc_mem_q[tail_q] <= fetch_pc_q;
      end
      if (resp_fill) begin
         inst_mem_q[fill_q] <= imem_resp_data;
      end
      if (redirect_valid && misalign) begin
         pc_mem_q[0]   <= target_pc;
         inst_mem_q[0] <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         filled_q <= '0;
`ifdef IF_ALIGN_CHECK_EN
         exc_q    <= '0;
`endif
      end else if (redirect_valid) begin
         filled_q <= '0;
`ifdef IF_ALIGN_CHECK_EN
         exc_q    <= '0;
         if (misalign) begin
            filled_q[0] <= 1'b1;
            exc_q[0]    <= 1'b1;
         end
`endif
      end else begin
         if (fire) begin
            filled_q[tail_q] <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            exc_q[tail_q]    <= 1'b0;
`endif
         end
         if (resp_fill) begin
            filled_q[fill_q] <= 1'b1;
         end
      end
   end

   always_comb begin
      id_valid = (count_q != '0) && filled_q[head_q];
      id_pc    = id_valid ? pc_mem_q[head_q]   : 32'h0;
      id_inst  = id_valid ? inst_mem_q[head_q] : 32'h0;
`ifdef IF_ALIGN_CHECK_EN
      id_exc   = id_valid && exc_q[head_q];
`endif
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: behavioural memory with programmable latency, expected-instruction queue and monitor.
// Honours IF_ALIGN_CHECK_EN the same way as the design.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
`ifdef IF_ALIGN_CHECK_EN
   logic        id_exc;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        exc;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   exp_t  expQ[$];
   pend_t pendQ[$];
   exp_t  monExp;
   int    checks  = 0;
   int    errors  = 0;
   int    cyc     = 0;
   int    memLat  = 1;
   int    fireCnt = 0;
   int    popCnt  = 0;

   if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_pc           (id_pc),
      .id_inst         (id_inst)
`ifdef IF_ALIGN_CHECK_EN
      ,
      .id_exc          (id_exc)
`endif
   );

   always #5 clk = ~clk;

   // Memory image: word at address a holds ((a/4)+1)*0x11, so 0x0->0x11, 0x4->0x22, 0x8->0x33.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return ((a >> 2) + 32'd1) * 32'h11;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic reqReady, input logic idReady);
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_req_ready = reqReady;
      id_ready       = idReady;
   endtask

   task automatic pushExp(input logic [31:0] pc, input logic [31:0] inst, input logic exc);
      exp_t e;
      e.pc   = pc;
      e.inst = inst;
      e.exc  = exc;
      expQ.push_back(e);
   endtask

   task automatic pushStream(input logic [31:0] startPc, input int n);
      for (int i = 0; i < n; i++) begin
         pushExp(startPc + 32'(4 * i), memWord(startPc + 32'(4 * i)), 1'b0);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      stepCycle();
      stepCycle();
      rst = 1'b0;
      #1;
   endtask

   task automatic waitDrain(input string tag);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 100) begin
         stepCycle();
         n++;
      end
      checkOutput({tag, "_drained"}, 32'(expQ.size()), 32'd0);
      expQ.delete();
      id_ready = 1'b0;
   endtask

   // Memory model: in-order responses memLat cycles after accept; pre-reset requests are forgotten.
   always @(negedge clk) begin
      cyc++;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      if (rst) begin
         pendQ.delete();
      end else begin
         if (pendQ.size() > 0 && pendQ[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memWord(pendQ[0].addr);
            void'(pendQ.pop_front());
         end
         if (imem_req_valid && imem_req_ready) begin
            pendQ.push_back('{addr: imem_req_addr, due: cyc + memLat});
            fireCnt++;
         end
      end
   end

   // Monitor: every accepted decode handshake outside a redirect cycle must match the next expected entry.
   always @(negedge clk) begin
      if (!rst && id_valid && id_ready && !redirect_valid) begin
         popCnt++;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedPop: got pc=%h inst=%h, required no instruction", id_pc, id_inst);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("popPc", id_pc, monExp.pc);
            checkOutput("popInst", id_inst, monExp.inst);
`ifdef IF_ALIGN_CHECK_EN
            checkOutput("popExc", 32'(id_exc), 32'(monExp.exc));
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int p0;
      int f0;

      // Straight-line fetch with single-cycle memory.
      memLat = 1;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      pushExp(32'h0, 32'h11, 1'b0);
      pushExp(32'h4, 32'h22, 1'b0);
      pushExp(32'h8, 32'h33, 1'b0);
      pushStream(32'hC, 5);
      doReset();
      checkOutput("a_c0_reqValid", 32'(imem_req_valid), 32'd1);
      checkOutput("a_c0_reqAddr", imem_req_addr, 32'h0);
      checkOutput("a_c0_idValid", 32'(id_valid), 32'd0);
      checkOutput("a_c0_idPc", id_pc, 32'h0);
      checkOutput("a_c0_idInst", id_inst, 32'h0);
      stepCycle();
      checkOutput("a_c1_reqAddr", imem_req_addr, 32'h4);
      checkOutput("a_c1_idValid", 32'(id_valid), 32'd0);
      stepCycle();
      checkOutput("a_c2_reqAddr", imem_req_addr, 32'h8);
      checkOutput("a_c2_idValid", 32'(id_valid), 32'd1);
      checkOutput("a_c2_idInst", id_inst, 32'h11);
      p0 = popCnt;
      for (int i = 0; i < 6; i++) begin
         stepCycle();
      end
      checkOutput("a_throughput", 32'(popCnt - p0), 32'd6);
      waitDrain("a");

      // Decode stall: queue fills to DEPTH, then drains in order and fetch resumes at 0x10.
      memLat = 1;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      doReset();
      f0 = fireCnt;
      for (int i = 0; i < 10; i++) begin
         stepCycle();
      end
      checkOutput("b_fires", 32'(fireCnt - f0), 32'd4);
      checkOutput("b_fullReqValid", 32'(imem_req_valid), 32'd0);
      checkOutput("b_headPc", id_pc, 32'h0);
      pushStream(32'h0, 6);
      id_ready = 1'b1;
      stepCycle();
      checkOutput("b_resumeValid", 32'(imem_req_valid), 32'd1);
      checkOutput("b_resumeAddr", imem_req_addr, 32'h10);
      waitDrain("b");

      // Redirect with three stale fetches in flight under latency 3.
      memLat = 3;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      pushStream(32'h100, 8);
      doReset();
      stepCycle();
      stepCycle();
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("c_redirValid", 32'(imem_req_valid), 32'd1);
      checkOutput("c_redirAddr", imem_req_addr, 32'h100);
      waitDrain("c");

      // Redirect in the same cycle as a request fire and a response arrival.
      memLat = 2;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      pushStream(32'h200, 8);
      doReset();
      stepCycle();
      stepCycle();
      applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("d_redirAddr", imem_req_addr, 32'h200);
      stepCycle();
      stepCycle();
      checkOutput("d_noStale", 32'(id_valid), 32'd0);
      waitDrain("d");

      // Misaligned redirect target on a full, idle queue.
      memLat = 1;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      doReset();
      for (int i = 0; i < 8; i++) begin
         stepCycle();
      end
      applyStimulus(1'b1, 32'h102, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
`ifdef IF_ALIGN_CHECK_EN
      checkOutput("e_excValid", 32'(id_valid), 32'd1);
      checkOutput("e_excPc", id_pc, 32'h102);
      checkOutput("e_excInst", id_inst, 32'h0);
      checkOutput("e_excFlag", 32'(id_exc), 32'd1);
      checkOutput("e_haltValid", 32'(imem_req_valid), 32'd0);
      f0 = fireCnt;
      pushExp(32'h102, 32'h0, 1'b1);
      id_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         stepCycle();
      end
      checkOutput("e_noFetch", 32'(fireCnt - f0), 32'd0);
      checkOutput("e_emptyAfter", 32'(id_valid), 32'd0);
      pushStream(32'h200, 4);
      applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("e_resumeValid", 32'(imem_req_valid), 32'd1);
      checkOutput("e_resumeAddr", imem_req_addr, 32'h200);
`else
      checkOutput("e_alignValid", 32'(imem_req_valid), 32'd1);
      checkOutput("e_alignAddr", imem_req_addr, 32'h100);
      checkOutput("e_alignIdValid", 32'(id_valid), 32'd0);
      pushStream(32'h100, 4);
      id_ready = 1'b1;
`endif
      waitDrain("e");

      // Reset asserted mid-stream with the queue full.
      for (int i = 0; i < 8; i++) begin
         stepCycle();
      end
      checkOutput("f_fullReqValid", 32'(imem_req_valid), 32'd0);
      checkOutput("f_fullIdValid", 32'(id_valid), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("f_rstReqValid", 32'(imem_req_valid), 32'd0);
      stepCycle();
      rst = 1'b0;
      #1;
      checkOutput("f_idValid", 32'(id_valid), 32'd0);
      checkOutput("f_idPc", id_pc, 32'h0);
      checkOutput("f_idInst", id_inst, 32'h0);
      checkOutput("f_reqValid", 32'(imem_req_valid), 32'd1);
      checkOutput("f_reqAddr", imem_req_addr, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
